// File: rtl/fifo_bank4_if.sv
// Handshake bundle between the upstream writer/arbiter (master) and the FIFO bank (slave).
interface fifo_bank4_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] data_in;
  logic [3:0]            push;
  logic [3:0]            pop;
  logic [DATA_WIDTH-1:0] fifo_out;
  logic                  valid_out;
  logic [3:0]            empty;
  logic [3:0]            almost_full;
  logic [3:0]            full;
  logic [3:0]            error;

  modport master (
    output data_in, push, pop,
    input  fifo_out, valid_out, empty, almost_full, full, error
  );

  modport slave (
    input  data_in, push, pop,
    output fifo_out, valid_out, empty, almost_full, full, error
  );
endinterface

// File: rtl/fifo_bank4.sv
// Four independent synchronous FIFOs sharing one write port and one registered read port.
// Flags are registered from the post-operation count; error bits are sticky until reset.
module fifo_bank4 #(
  parameter int DATA_WIDTH     = 12,
  parameter int DEPTH          = 8,
  parameter int ADDR_WIDTH     = 3,
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic           clk,
  input  logic           reset,
  fifo_bank4_if.slave    bus
);
  localparam int NUM_FIFOS = 4;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem       [NUM_FIFOS][DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr    [NUM_FIFOS];
  logic [ADDR_WIDTH-1:0] rd_ptr    [NUM_FIFOS];
  logic [ADDR_WIDTH:0]   count     [NUM_FIFOS];
  logic [ADDR_WIDTH:0]   count_nxt [NUM_FIFOS];

  logic [NUM_FIFOS-1:0] wr_en;
  logic [NUM_FIFOS-1:0] rd_en;
  logic [1:0]           rd_sel;
  logic                 push_multi;
  logic                 pop_multi;
  logic                 overflow_hit;
  logic                 underflow_hit;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    push_multi    = (bus.push & (bus.push - 4'd1)) != 4'd0;
    pop_multi     = (bus.pop  & (bus.pop  - 4'd1)) != 4'd0;
    wr_en         = '0;
    rd_en         = '0;
    rd_sel        = '0;
    overflow_hit  = 1'b0;
    underflow_hit = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      rd_en[i] = !pop_multi && bus.pop[i] && (count[i] != '0);
      // A full FIFO still accepts a push when the same FIFO is popped this cycle.
      wr_en[i] = !push_multi && bus.push[i] && ((count[i] != FULL_CNT) || rd_en[i]);
      if (!pop_multi && bus.pop[i] && (count[i] == '0))
        underflow_hit = 1'b1;
      if (!push_multi && bus.push[i] && (count[i] == FULL_CNT) && !rd_en[i])
        overflow_hit = 1'b1;
      if (rd_en[i])
        rd_sel = 2'(i);
      case ({wr_en[i], rd_en[i]})
        2'b10:   count_nxt[i] = count[i] + CNT_ONE;
        2'b01:   count_nxt[i] = count[i] - CNT_ONE;
        default: count_nxt[i] = count[i];
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and counts alone define which words are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (reset && wr_en[i])
        mem[i][wr_ptr[i]] <= bus.data_in;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      bus.fifo_out    <= '0;
      bus.valid_out   <= 1'b0;
      bus.empty       <= 4'b1111;
      bus.almost_full <= '0;
      bus.full        <= '0;
      bus.error       <= '0;
    end else begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (wr_en[i])
          wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (rd_en[i])
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        count[i]           <= count_nxt[i];
        bus.empty[i]       <= (count_nxt[i] == '0);
        bus.almost_full[i] <= (count_nxt[i] >= AF_CNT);
        bus.full[i]        <= (count_nxt[i] == FULL_CNT);
      end
      bus.valid_out <= |rd_en;
      if (|rd_en)
        bus.fifo_out <= mem[rd_sel][rd_ptr[rd_sel]];
      bus.error <= bus.error | {pop_multi, push_multi, underflow_hit, overflow_hit};
    end
  end
endmodule

// File: tb/tb_fifo_bank4.sv
// Directed bench for fifo_bank4: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fifo_bank4;
  localparam int DEPTH = 8;
  localparam int AF_TH = 6;

  logic clk;
  logic reset;
  fifo_bank4_if #(.DATA_WIDTH(12)) bus();

  fifo_bank4 #(
    .DATA_WIDTH(12), .DEPTH(DEPTH), .ADDR_WIDTH(3), .ALMOST_FULL_TH(AF_TH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each FIFO is a queue; pop is applied before push so a same-cycle
  // pop on a full FIFO frees the slot and a pop on an empty FIFO sees nothing.
  logic [11:0] q [4][$];
  logic [11:0] m_out;
  logic        m_valid;
  logic [3:0]  m_err;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_err   = '0;
    end else begin
      m_valid = 1'b0;
      if ($countones(bus.pop) > 1) m_err[3] = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.pop[i]) begin
            if (q[i].size() > 0) begin
              m_out   = q[i].pop_front();
              m_valid = 1'b1;
            end else m_err[1] = 1'b1;
          end
        end
      end
      if ($countones(bus.push) > 1) m_err[2] = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.push[i]) begin
            if (q[i].size() < DEPTH) q[i].push_back(bus.data_in);
            else m_err[0] = 1'b1;
          end
        end
      end
    end
  end

  logic [3:0] e_empty, e_af, e_full;
  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 4; i++) begin
        e_empty[i] = (q[i].size() == 0);
        e_af[i]    = (q[i].size() >= AF_TH);
        e_full[i]  = (q[i].size() == DEPTH);
      end
      check("model_valid_out",   32'(bus.valid_out),   32'(m_valid));
      check("model_fifo_out",    32'(bus.fifo_out),    32'(m_out));
      check("model_empty",       32'(bus.empty),       32'(e_empty));
      check("model_almost_full", 32'(bus.almost_full), 32'(e_af));
      check("model_full",        32'(bus.full),        32'(e_full));
      check("model_error",       32'(bus.error),       32'(m_err));
    end
  end

  // One clock: apply inputs, let the edge sample them, return 1 time unit after the edge.
  task automatic cyc(input logic [3:0] pu, input logic [3:0] po, input logic [11:0] d);
    bus.push    = pu;
    bus.pop     = po;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.push = '0;
    bus.pop  = '0;
  endtask

  initial begin
    reset       = 1'b0;
    bus.push    = '0;
    bus.pop     = '0;
    bus.data_in = '0;

    // 1: reset held two cycles
    cyc(4'b0000, 4'b0000, 12'h0);
    cyc(4'b0000, 4'b0000, 12'h0);
    check_en = 1'b1;
    check("rst_empty",  32'(bus.empty),       32'hF);
    check("rst_af",     32'(bus.almost_full), 32'h0);
    check("rst_full",   32'(bus.full),        32'h0);
    check("rst_valid",  32'(bus.valid_out),   32'h0);
    check("rst_out",    32'(bus.fifo_out),    32'h0);
    check("rst_error",  32'(bus.error),       32'h0);
    reset = 1'b1;

    // 2: four pushes then four pops on FIFO0
    for (int k = 0; k < 4; k++) cyc(4'b0001, 4'b0000, 12'h096);
    check("f0_not_empty", 32'(bus.empty[0]), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0000, 4'b0001, 12'h0);
      check("f0_pop_data",  32'(bus.fifo_out),  32'h096);
      check("f0_pop_valid", 32'(bus.valid_out), 32'h1);
      check("f0_empty_flag", 32'(bus.empty[0]), (k == 3) ? 32'h1 : 32'h0);
    end
    cyc(4'b0000, 4'b0000, 12'h0);
    check("f0_idle_valid", 32'(bus.valid_out), 32'h0);
    check("f0_idle_hold",  32'(bus.fifo_out),  32'h096);

    // 3: fill FIFO2, overflow, drain in order, then wrap again
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0100, 4'b0000, 12'(12'h100 + k));
      check("f2_af",   32'(bus.almost_full[2]), (k >= 5) ? 32'h1 : 32'h0);
      check("f2_full", 32'(bus.full[2]),        (k == 7) ? 32'h1 : 32'h0);
    end
    cyc(4'b0100, 4'b0000, 12'h1FF);
    check("f2_overflow_err", 32'(bus.error), 32'h1);
    check("f2_still_full",   32'(bus.full[2]), 32'h1);
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0000, 4'b0100, 12'h0);
      check("f2_order", 32'(bus.fifo_out), 32'(12'h100 + k));
    end
    check("f2_empty", 32'(bus.empty[2]), 32'h1);
    cyc(4'b0100, 4'b0000, 12'h3A1);
    cyc(4'b0100, 4'b0000, 12'h3A2);
    cyc(4'b0000, 4'b0100, 12'h0);
    check("f2_wrap1", 32'(bus.fifo_out), 32'h3A1);
    cyc(4'b0000, 4'b0100, 12'h0);
    check("f2_wrap2", 32'(bus.fifo_out), 32'h3A2);

    // 4: simultaneous push+pop on a one-word FIFO1
    cyc(4'b0010, 4'b0000, 12'h8F0);
    cyc(4'b0010, 4'b0010, 12'hDA0);
    check("f1_pp_data",  32'(bus.fifo_out),  32'h8F0);
    check("f1_pp_valid", 32'(bus.valid_out), 32'h1);
    check("f1_pp_count", 32'(bus.empty[1]),  32'h0);
    cyc(4'b0000, 4'b0010, 12'h0);
    check("f1_second",   32'(bus.fifo_out),  32'hDA0);
    check("f1_empty",    32'(bus.empty[1]),  32'h1);

    // 5: underflow, multi-hot push, multi-hot pop
    cyc(4'b0000, 4'b0100, 12'h0);
    check("uf_valid", 32'(bus.valid_out), 32'h0);
    check("uf_hold",  32'(bus.fifo_out),  32'hDA0);
    check("uf_error", 32'(bus.error),     32'h3);
    cyc(4'b0011, 4'b0000, 12'h555);
    check("mh_push_err",   32'(bus.error), 32'h7);
    check("mh_push_nowr",  32'(bus.empty), 32'hF);
    cyc(4'b0000, 4'b0011, 12'h0);
    check("mh_pop_err",    32'(bus.error), 32'hF);

    // full FIFO0 with same-cycle push+pop keeps count at DEPTH
    for (int k = 0; k < 8; k++) cyc(4'b0001, 4'b0000, 12'(12'h200 + k));
    cyc(4'b0001, 4'b0001, 12'h2AA);
    check("full_pp_data", 32'(bus.fifo_out), 32'h200);
    check("full_pp_full", 32'(bus.full[0]),  32'h1);
    // empty FIFO1 with same-cycle push+pop: push only
    cyc(4'b0010, 4'b0010, 12'h777);
    check("empty_pp_valid", 32'(bus.valid_out), 32'h0);
    check("empty_pp_count", 32'(bus.empty[1]),  32'h0);

    // 6: reset mid-operation discards data
    for (int k = 0; k < 5; k++) cyc(4'b1000, 4'b0000, 12'(12'h4C0 + k));
    check("f3_five_af", 32'(bus.almost_full[3]), 32'h0);
    check("f3_five_ne", 32'(bus.empty[3]),       32'h0);
    reset = 1'b0;
    cyc(4'b0000, 4'b0000, 12'h0);
    reset = 1'b1;
    check("rst2_empty", 32'(bus.empty),    32'hF);
    check("rst2_error", 32'(bus.error),    32'h0);
    check("rst2_out",   32'(bus.fifo_out), 32'h0);
    check("rst2_full",  32'(bus.full),     32'h0);
    cyc(4'b0000, 4'b1000, 12'h0);
    check("rst2_uf_err",   32'(bus.error),     32'h2);
    check("rst2_uf_valid", 32'(bus.valid_out), 32'h0);
    cyc(4'b0000, 4'b0000, 12'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
